// File: rtl/sram_dual_port_scheduler.sv
// Schedules requesters A (CPU) and B (DMA) onto a 1RW+1R SRAM macro.
// Reads prefer the read-only port 1; writes, and a second same-cycle read, use port 0.
module sram_dual_port_scheduler #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  a_valid,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic a_v, b_v, a_rd, a_wr, b_rd, b_wr;
    logic a_gnt, b_gnt, a_on_p1, b_on_p1, refused;
    logic rr_ptr_q, rr_ptr_d;
    logic a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic a_psel_q, a_psel_d, b_psel_q, b_psel_d;
    logic a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Grant decode; requests are masked while reset is asserted so the macro idles.
    always_comb begin
        a_v      = a_valid & HRESETn;
        b_v      = b_valid & HRESETn;
        a_rd     = a_v & ~a_we;
        a_wr     = a_v & a_we;
        b_rd     = b_v & ~b_we;
        b_wr     = b_v & b_we;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        a_on_p1  = 1'b0;
        b_on_p1  = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (a_v && b_v) begin
            if (a_rd && b_rd) begin
                a_gnt   = 1'b1;
                b_gnt   = 1'b1;
                a_on_p1 = 1'b1;
            end else if (a_wr && b_wr) begin
                a_gnt    = ~rr_ptr_q;
                b_gnt    = rr_ptr_q;
                rr_ptr_d = ~rr_ptr_q;
            end else if (a_addr == b_addr) begin
                a_gnt = a_wr;
                b_gnt = b_wr;
            end else begin
                a_gnt   = 1'b1;
                b_gnt   = 1'b1;
                a_on_p1 = a_rd;
                b_on_p1 = b_rd;
            end
        end else begin
            a_gnt   = a_v;
            b_gnt   = b_v;
            a_on_p1 = a_rd;
            b_on_p1 = b_rd;
        end
        a_ready = a_gnt;
        b_ready = b_gnt;
    end

    // Macro port steering; every field returns to zero when its port is idle.
    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
        if (a_gnt && !a_on_p1) begin
            csb0   = 1'b0;
            web0   = ~a_we;
            wmask0 = a_we ? a_wmask : '0;
            addr0  = a_addr;
            din0   = a_we ? a_wdata : '0;
        end else if (b_gnt && !b_on_p1) begin
            csb0   = 1'b0;
            web0   = ~b_we;
            wmask0 = b_we ? b_wmask : '0;
            addr0  = b_addr;
            din0   = b_we ? b_wdata : '0;
        end
        if (a_gnt && a_on_p1) begin
            csb1  = 1'b0;
            addr1 = a_addr;
        end else if (b_gnt && b_on_p1) begin
            csb1  = 1'b0;
            addr1 = b_addr;
        end
    end

    // Read return pipeline: pend marks E0 acceptance, data is captured at E1.
    always_comb begin
        a_pend_d   = a_gnt & ~a_we;
        b_pend_d   = b_gnt & ~b_we;
        a_psel_d   = a_pend_d ? a_on_p1 : a_psel_q;
        b_psel_d   = b_pend_d ? b_on_p1 : b_psel_q;
        a_rvalid_d = a_pend_q;
        b_rvalid_d = b_pend_q;
        a_rdata_d  = a_pend_q ? (a_psel_q ? dout1 : dout0) : a_rdata_q;
        b_rdata_d  = b_pend_q ? (b_psel_q ? dout1 : dout0) : b_rdata_q;
        refused    = (a_v & ~a_gnt) | (b_v & ~b_gnt);
        cnt_d      = cnt_q;
        if (refused && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_ptr_q   <= 1'b0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            a_psel_q   <= 1'b0;
            b_psel_q   <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            a_pend_q   <= a_pend_d;
            b_pend_q   <= b_pend_d;
            a_psel_q   <= a_psel_d;
            b_psel_q   <= b_psel_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_dual_port_scheduler.sv
// Scoreboard bench for sram_dual_port_scheduler with a behavioural SRAM macro
// and a reference model of grants, memory contents and the conflict counter.
module tb_sram_dual_port_scheduler;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        a_valid, a_we, b_valid, b_we;
    logic [3:0]  a_wmask, b_wmask;
    logic [8:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0, dout0, dout1;
    logic [15:0] conflict_cnt;

    sram_dual_port_scheduler dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .a_valid(a_valid), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1),
        .conflict_cnt(conflict_cnt)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
        return r;
    endfunction

    // Macro model: controls sampled at the rising edge, write and read data at the falling edge.
    logic [31:0] mem [512];
    logic        m_wr, m_rd0, m_rd1;
    logic [8:0]  m_a0, m_a1;
    logic [31:0] m_d0;
    logic [3:0]  m_m0;
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[3] = 32'h11;
        mem[7] = 32'h77;
        dout0 = '0;
        dout1 = '0;
        forever begin
            @(posedge HCLK);
            m_wr  = !csb0 && !web0;
            m_rd0 = !csb0 && web0;
            m_rd1 = !csb1;
            m_a0  = addr0;
            m_a1  = addr1;
            m_d0  = din0;
            m_m0  = wmask0;
            #1;
            dout0 = $urandom;
            dout1 = $urandom;
            @(negedge HCLK);
            if (m_wr)  mem[m_a0] = merge(mem[m_a0], m_d0, m_m0);
            if (m_rd0) dout0 = mem[m_a0];
            if (m_rd1) dout1 = mem[m_a1];
        end
    end

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] refmem [512];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        rr_m;
    int          cnt_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of requests, compare against the reference model, advance one edge.
    task automatic drive(input logic av, input logic awe, input logic [3:0] am,
                         input logic [8:0] aad, input logic [31:0] ad,
                         input logic bv, input logic bwe, input logic [3:0] bm,
                         input logic [8:0] bad_, input logic [31:0] bd);
        logic ga, gb, pa1, pb1, p0_busy, p1_busy, wr0;
        a_valid = av; a_we = awe; a_wmask = am; a_addr = aad; a_wdata = ad;
        b_valid = bv; b_we = bwe; b_wmask = bm; b_addr = bad_; b_wdata = bd;
        #1;
        pa1 = !awe;
        pb1 = !bwe;
        if (av && bv) begin
            if (!awe && !bwe) begin
                ga = 1; gb = 1; pb1 = 0;
            end else if (awe && bwe) begin
                ga = !rr_m; gb = rr_m;
            end else if (aad == bad_) begin
                ga = awe; gb = bwe;
            end else begin
                ga = 1; gb = 1;
            end
        end else begin
            ga = av; gb = bv;
        end
        p1_busy = (ga && !awe && pa1) || (gb && !bwe && pb1);
        p0_busy = (ga && (awe || !pa1)) || (gb && (bwe || !pb1));
        wr0     = (ga && awe) || (gb && bwe);
        check("a_ready", 32'(a_ready), 32'(ga));
        check("b_ready", 32'(b_ready), 32'(gb));
        check("csb1", 32'(csb1), 32'(!p1_busy));
        check("csb0", 32'(csb0), 32'(!p0_busy));
        check("web0", 32'(web0), 32'(!wr0));
        check("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
        if (!p0_busy) check("idle_port0", {addr0, wmask0, din0[18:0]}, 32'd0);
        if (!p1_busy) check("idle_addr1", 32'(addr1), 32'd0);
        if (ga && !awe) qa.push_back('{refmem[aad], cyc + 2});
        if (gb && !bwe) qb.push_back('{refmem[bad_], cyc + 2});
        if (ga && awe) refmem[aad] = merge(refmem[aad], ad, am);
        if (gb && bwe) refmem[bad_] = merge(refmem[bad_], bd, bm);
        if (((av && !ga) || (bv && !gb)) && cnt_m != 65535) cnt_m++;
        if (av && bv && awe && bwe) rr_m = !rr_m;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 9'd0, 32'd0, 0, 0, 4'h0, 9'd0, 32'd0);
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge HCLK);
            if (HRESETn) begin
                if (qa.size() > 0 && qa[0].due == cyc) begin
                    check("a_rvalid", 32'(a_rvalid), 32'd1);
                    check("a_rdata", a_rdata, qa[0].d);
                    void'(qa.pop_front());
                end else if (a_rvalid) begin
                    check("a_rvalid_spurious", 32'(a_rvalid), 32'd0);
                end
                if (qb.size() > 0 && qb[0].due == cyc) begin
                    check("b_rvalid", 32'(b_rvalid), 32'd1);
                    check("b_rdata", b_rdata, qb[0].d);
                    void'(qb.pop_front());
                end else if (b_rvalid) begin
                    check("b_rvalid_spurious", 32'(b_rvalid), 32'd0);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) refmem[i] = '0;
        refmem[3] = 32'h11;
        refmem[7] = 32'h77;
        rr_m = 0;
        cnt_m = 0;
        HRESETn = 0;
        a_valid = 1; a_we = 0; a_wmask = 0; a_addr = 9'd4; a_wdata = 0;
        b_valid = 0; b_we = 0; b_wmask = 0; b_addr = 0; b_wdata = 0;
        fork
            forever begin
                @(posedge HCLK);
                cyc++;
            end
            monitor_loop();
        join_none
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_csb", {csb0, csb1}, 32'd3);
        check("rst_cnt", 32'(conflict_cnt), 32'd0);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 32'd0);
        check("rst_rdata", a_rdata | b_rdata, 32'd0);
        a_valid = 0;
        @(negedge HCLK);
        HRESETn = 1;
        @(posedge HCLK);
        #1;

        // Write then read back on A.
        drive(1, 1, 4'hF, 9'd5, 32'hDEADBEEF, 0, 0, 4'h0, 9'd0, 32'd0);
        drive(1, 0, 4'h0, 9'd5, 32'd0, 0, 0, 4'h0, 9'd0, 32'd0);
        idle(2);
        // Dual read, one per port.
        drive(1, 0, 4'h0, 9'd3, 32'd0, 1, 0, 4'h0, 9'd7, 32'd0);
        idle(2);
        // Same-address write/read: write first, held read accepted next cycle.
        drive(1, 1, 4'hF, 9'd9, 32'h1234, 1, 0, 4'h0, 9'd9, 32'd0);
        drive(0, 0, 4'h0, 9'd0, 32'd0, 1, 0, 4'h0, 9'd9, 32'd0);
        idle(2);
        check("cnt_after_rw", 32'(conflict_cnt), 32'd1);
        // Both writing: grants alternate A, B, A, B.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'hF, 9'd1, 32'hA000 + 32'(i), 1, 1, 4'hF, 9'd2, 32'hB000 + 32'(i));
        end
        check("cnt_after_ww", 32'(conflict_cnt), 32'd5);
        drive(1, 0, 4'h0, 9'd1, 32'd0, 1, 0, 4'h0, 9'd2, 32'd0);
        // Partial-mask write over zero.
        drive(1, 1, 4'b0101, 9'd0, 32'hAABBCCDD, 0, 0, 4'h0, 9'd0, 32'd0);
        drive(1, 0, 4'h0, 9'd0, 32'd0, 0, 0, 4'h0, 9'd0, 32'd0);
        idle(2);
        check("mask_ref", refmem[0], 32'h00BB00DD);

        // Reset between acceptance and return of a read.
        drive(1, 0, 4'h0, 9'd5, 32'd0, 1, 0, 4'h0, 9'd3, 32'd0);
        HRESETn = 0;
        qa.delete();
        qb.delete();
        rr_m = 0;
        cnt_m = 0;
        #1;
        check("midrst_csb", {csb0, csb1}, 32'd3);
        check("midrst_ready", {a_ready, b_ready}, 32'd0);
        check("midrst_cnt", 32'(conflict_cnt), 32'd0);
        a_valid = 0;
        b_valid = 0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1;
        @(posedge HCLK);
        #1;
        check("midrst_rvalid", {a_rvalid, b_rvalid}, 32'd0);
        idle(2);

        // Randomised traffic on a small address window to force conflicts.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom),
                  9'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom),
                  9'($urandom_range(0, 7)), $urandom);
        end
        idle(3);
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_dual_port_scheduler.md
Name: sram_dual_port_scheduler

Overview:
- Schedules two requesters, A (CPU data side) and B (DMA side), onto one sky130_sram_2kbyte_1rw1r_32x512_8 macro.
- Per cycle it issues up to two operations: writes and overflow reads on port 0 (RW), preferred reads on port 1 (R-only).
- It resolves write/write and same-address read/write conflicts, arbitrates round-robin, and returns registered read data with fixed 1-cycle latency.
- Both macro clocks (clk0, clk1) are tied to HCLK at the integration level.

Parameters:
- ADDR_WIDTH, 9, word address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-lane write-enable count (DATA_WIDTH/8)
- CNT_WIDTH, 16, width of the conflict counter

Ports:
- HCLK  in  1  clock; all logic is on the rising edge
- HRESETn  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A request
- a_we  in  1  1 = write, 0 = read
- a_wmask  in  NUM_WMASKS  byte enables, used on writes
- a_addr  in  ADDR_WIDTH  word address
- a_wdata  in  DATA_WIDTH  write data
- a_ready  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_WIDTH  A read data
- b_valid, b_we, b_wmask, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as the A set, for requester B
- csb0, web0  out  1 each  macro port 0 controls, active low
- wmask0  out  NUM_WMASKS  macro port 0 byte mask
- addr0  out  ADDR_WIDTH  macro port 0 address
- din0  out  DATA_WIDTH  macro port 0 write data
- dout0  in  DATA_WIDTH  macro port 0 read data
- csb1  out  1  macro port 1 select, active low
- addr1  out  ADDR_WIDTH  macro port 1 address
- dout1  in  DATA_WIDTH  macro port 1 read data
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles in which a valid request was refused

Behaviour:
- Grant decode:
  - Combinational from the valids, the request fields and the rr_ptr register (0 = A has priority).
  - The macro control outputs and a_ready/b_ready are driven in the same cycle.
  - A request is accepted at the rising edge where valid && ready.
- Case table, granted op → port:
  - Only one requester valid: a read goes to port 1; a write goes to port 0.
  - Both reads: A on port 1, B on port 0 (web0=1, wmask0=0); both ready. Same address is allowed.
  - One write, one read, different addresses: write on port 0, read on port 1; both ready.
  - One write, one read, same address: the write is granted, the read gets ready=0 (write-first); conflict event.
  - Both writes: the rr_ptr winner is granted on port 0, the loser gets ready=0; conflict event.
- Round-robin pointer:
  - rr_ptr changes only on a both-write conflict.
  - After the conflict it points to the loser, so the loser wins the next contention.
- Idle port values:
  - csb0=1, csb1=1, web0=1, wmask0=0.
  - addr/din hold 0 when idle, so there is no spurious macro activity.
- Write timing: the macro commits on the falling edge after acceptance. A read of the same address accepted at the next rising edge returns the new data.
- Read latency:
  - Accept at edge E0; the macro's data is stable before E1 and goes X shortly after E1.
  - At E1, a_rdata/b_rdata capture dout0 or dout1, chosen by a per-requester registered port-select flag set at E0.
  - a_rvalid/b_rvalid are high for exactly the E1..E2 cycle.
  - Back-to-back reads give one rvalid per cycle, in order.
- rdata holds its value when rvalid=0.
- Writes produce no response.
- conflict_cnt increments by 1 on each cycle containing ≥1 refused valid request and saturates at all-ones.
- Requests are not required to hold while ready=0, but requesters hold them by protocol. The scheduler treats each cycle independently, with no internal queue.
- Reset, asynchronous, effective immediately:
  - rr_ptr=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, conflict_cnt=0, port-select flags=0.
  - Combinational outputs go to the idle values while HRESETn=0 (ready=0, csb0=csb1=1).
- Reset mid-read: a read accepted at E0 with reset asserted before E1 produces no rvalid after reset release.
- Reset release: takes effect at the first rising edge with HRESETn=1. No state is held over.

Test Plan:
- A writes 0xDEADBEEF to addr 5 (mask 0xF), then reads addr 5 → A read accepted the next cycle, a_rvalid one cycle later, a_rdata=0xDEADBEEF, csb1=0 on the read.
- A and B read addrs 3 and 7 in the same cycle (preloaded 0x11, 0x77) → both ready. Next cycle a_rvalid=b_rvalid=1, a_rdata=0x11, b_rdata=0x77.
- A writes addr 9 = 0x1234 while B reads addr 9, both held → cycle 1: a_ready=1, b_ready=0, conflict_cnt=1. Cycle 2: B accepted, b_rdata=0x1234 one cycle later.
- A and B both write continuously to addrs 1 and 2 for 4 cycles → grants alternate A, B, A, B; conflict_cnt=4.
- A writes addr 0 with wmask 0b0101, data 0xAABBCCDD, over old 0x00000000 → readback 0x00BB00DD.
- A read accepted, HRESETn pulsed low before the next edge → a_rvalid stays 0, conflict_cnt=0, csb0=csb1=1 during reset.
